// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot and auto-reload
// modes. It raises an interrupt when the programmed count expires.
// Register window (word index = addr[3:2]):
//   0 CTRL   {IM, MODE[1:0], EN}  read/write; a write also clears the flag
//   1 PRESET reload value          read/write
//   2 COUNT  current count         read-only
//   3 reserved                     reads 0, writes ignored
// Bus handshake: there is no valid/ready pair. A transfer is a single-cycle
// access. When we=1 the write commits on the next rising edge. Reads are
// combinational from addr and never stall.
module timer_counter #(
  parameter int CTRL_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq,
  output logic [1:0]  state_o
);

  // CTRL bit positions
  localparam int EN_BIT   = 0;
  localparam int MODE_LO  = 1;
  localparam int MODE_HI  = 2;
  localparam int IM_BIT   = 3;

  // Encoding is fixed so state_o has a stable meaning for observers
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [31:0]         preset_q, preset_d;
  logic [31:0]         count_q, count_d;
  logic                flag_q, flag_d;
  logic                flag_set;
  logic                en;
  logic [1:0]          mode;

  assign en   = ctrl_q[EN_BIT];
  assign mode = ctrl_q[MODE_HI:MODE_LO];

  // The count expires in CNT while enabled. COUNT of 0 or 1 both end the run.
  assign flag_set = (state_q == CNT) && en && (count_q <= 32'd1);

  // Register update. A synchronous reset overrides every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Next state: the FSM acts first, then the bus write overrides CTRL/PRESET.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (mode == 2'b01) begin
          // Auto-reload: the flag lives for exactly the one INT cycle
          flag_d  = 1'b0;
          state_d = LOAD;
        end else begin
          // One-shot (MODE 10/11 behave the same): stop and keep the flag
          ctrl_d[EN_BIT] = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (we) begin
      case (addr[3:2])
        2'd0: begin
          ctrl_d = din[CTRL_W-1:0];
          // A flag raised on this same edge wins over the write's clear
          if (!flag_set) flag_d = 1'b0;
        end
        2'd1: preset_d = din;
        default: ;
      endcase
    end
  end

  // Read mux: combinational from the word index
  always_comb begin
    dout = '0;
    case (addr[3:2])
      2'd0: dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
      2'd1: dout = preset_q;
      2'd2: dout = count_q;
      default: dout = '0;
    endcase
  end

  assign irq     = ctrl_q[IM_BIT] & flag_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter. A timeline-based reference model predicts CTRL,
// PRESET, COUNT, irq and the observable phase after every clock edge.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  timer_counter #(.CTRL_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq     (irq),
    .state_o (state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Reference model. The phase values follow the documented state_o
  // meaning: 0 idle, 1 load pending, 2 counting, 3 expired.
  localparam int P_STOP = 0;
  localparam int P_ARM  = 1;
  localparam int P_RUN  = 2;
  localparam int P_EXP  = 3;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;     // COUNT whenever the timer is not running
  logic [31:0] m_load_val;  // value latched at the most recent load
  bit          m_flag;
  int          m_phase;
  longint      m_edges;
  longint      m_t_load;    // edge index at which the last load happened

  // While running, COUNT is the loaded value minus the edges elapsed
  function automatic logic [31:0] m_cnt();
    if (m_phase == P_RUN) return m_load_val - 32'(m_edges - m_t_load);
    return m_count;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_cnt();
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d);
    logic [31:0] cur;
    bit          set_flag;
    cur = m_cnt();
    m_edges++;
    set_flag = 1'b0;
    if (r) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_load_val = '0;
      m_flag = 1'b0; m_phase = P_STOP;
    end else begin
      case (m_phase)
        P_STOP: if (m_ctrl[0]) m_phase = P_ARM;
        P_ARM: begin
          m_load_val = m_preset;
          m_t_load   = m_edges;
          m_phase    = P_RUN;
        end
        P_RUN: begin
          if (!m_ctrl[0]) begin
            m_count = cur;
            m_phase = P_STOP;
          end else if (cur <= 32'd1) begin
            m_count  = 32'd0;
            set_flag = 1'b1;
            m_phase  = P_EXP;
          end
        end
        default: begin
          if (m_ctrl[2:1] == 2'b01) begin
            m_flag  = 1'b0;
            m_phase = P_ARM;
          end else begin
            m_ctrl[0] = 1'b0;
            m_phase   = P_STOP;
          end
        end
      endcase
      if (set_flag) m_flag = 1'b1;
      if (w && a[3:2] == 2'd0) begin
        m_ctrl = d[3:0];
        if (!set_flag) m_flag = 1'b0;
      end
      if (w && a[3:2] == 2'd1) m_preset = d;
    end
  endtask

  // scoreboard: compare one observed value against one expected value
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_edges);
    end
  endtask

  task automatic check_outputs();
    chk("dout", dout, m_read(addr));
    chk("irq", {31'b0, irq}, {31'b0, m_ctrl[3] & m_flag});
    chk("state", {30'b0, state_o}, 32'(m_phase));
  endtask

  // driver: apply one cycle of inputs, advance model, check after the edge
  task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    reset = r; we = w; addr = a; din = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a, $urandom);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  // Run idle cycles (reading COUNT) until the model shows the given count
  task automatic wait_count(input logic [31:0] v);
    for (int k = 0; k < 64 && !(m_phase == P_RUN && m_cnt() == v); k++)
      idle(1, 32'h8);
  endtask

  initial begin
    m_edges = 0; m_t_load = 0; m_phase = P_STOP;
    m_ctrl = '0; m_preset = '0; m_count = '0; m_load_val = '0; m_flag = 1'b0;
    reset = 1'b1; we = 1'b0; addr = '0; din = '0;

    // Reset, then read every register
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'h4, 32'h1234);
    idle(1, 32'h0);
    chk("rst_ctrl", dout, 32'd0);
    idle(1, 32'h4);
    chk("rst_preset", dout, 32'd0);
    idle(1, 32'h8);
    chk("rst_count", dout, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);

    // One-shot, PRESET=5: COUNT=5 at E2, irq rises at E7 and holds
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);            // E0
    idle(2, 32'h8);              // E2
    chk("os_load", dout, 32'd5);
    idle(4, 32'h8);              // E6
    chk("os_cnt1", dout, 32'd1);
    chk("os_noirq", {31'b0, irq}, 32'd0);
    idle(1, 32'h8);              // E7
    chk("os_irq", {31'b0, irq}, 32'd1);
    idle(3, 32'h0);
    chk("os_ctrl", dout, 32'h8);
    chk("os_hold", {31'b0, irq}, 32'd1);
    wr(32'h0, 32'h0);
    chk("os_clr", {31'b0, irq}, 32'd0);

    // Auto-reload, PRESET=3: pulses every 5 cycles
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    idle(20, 32'h8);
    wr(32'h0, 32'h0);
    idle(2, 32'h8);

    // Disable mid-count: COUNT freezes at 6, re-enable reloads to 10
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    wait_count(32'd7);
    wr(32'h0, 32'h0);
    idle(4, 32'h8);
    chk("frz", dout, 32'd6);
    wr(32'h0, 32'h1);
    idle(2, 32'h8);
    chk("reload", dout, 32'd10);
    wr(32'h0, 32'h0);

    // Masked one-shot, then writing IM=1 clears the flag
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    idle(8, 32'h8);
    chk("mask_irq", {31'b0, irq}, 32'd0);
    wr(32'h0, 32'h8);
    idle(2, 32'h0);
    chk("mask_clr", {31'b0, irq}, 32'd0);

    // PRESET=0 expires one cycle after the load
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    idle(5, 32'h8);
    wr(32'h0, 32'h0);

    // CTRL write on the expiring edge: flag set wins
    wr(32'h4, 32'd3);
    wr(32'h0, 32'h9);
    wait_count(32'd1);
    wr(32'h0, 32'h9);
    chk("race_set", {31'b0, irq}, 32'd1);
    // CTRL write while in INT: bus write wins and clears the flag
    wr(32'h0, 32'h9);
    idle(6, 32'h8);
    wr(32'h0, 32'h0);

    // Reset mid-count in auto-reload, then a COUNT write is ignored
    wr(32'h4, 32'd6);
    wr(32'h0, 32'hB);
    wait_count(32'd4);
    cyc(1'b1, 1'b0, 32'h8, 32'h0);
    chk("mrst_cnt", dout, 32'd0);
    wr(32'h8, 32'h55);
    chk("ro_cnt", dout, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = $urandom;
      d = (a[3:2] == 2'd1) ? $urandom_range(0, 6) : $urandom;
      cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 4) == 0), a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
